// File: rtl/rram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rram_pkg
//  Description : Shared types and constants for the RRAM ring-cell read
//                controller (FSM state encoding, counter default width,
//                synchronizer depth).
//  Revision    : 1.0  initial release
// ============================================================================
package rram_pkg;

    localparam int CNT_W_DEFAULT = 16;
    localparam int SYNC_STAGES   = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DISCHARGE = 3'd1,
        POWER     = 3'd2,
        SYNC      = 3'd3,
        SAMP1     = 3'd4,
        SAMP2     = 3'd5,
        FINISH    = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/rram_sync.sv
`default_nettype none
// ============================================================================
//  Module      : rram_sync
//  Description : WIDTH-bit multi-flop synchronizer bringing the asynchronous
//                ring outputs into the clk domain. Nothing but flops.
//  Revision    : 1.0  initial release
// ============================================================================
module rram_sync
    import rram_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    // First stage captures the raw (possibly metastable) input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q[0] <= '0;
        end else begin
            stage_q[0] <= async_i;
        end
    end

    generate
        for (genvar s = 1; s < SYNC_STAGES; s++) begin : g_stage
            // Each further stage resolves metastability of the previous one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_q[s] <= '0;
                end else begin
                    stage_q[s] <= stage_q[s-1];
                end
            end
        end
    endgenerate

    assign sync_o = stage_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rram_ctrl
//  Description : Power-up / read sequencer for an array of ring-oscillator
//                RRAM cells. Discharges the array, powers the masked cells,
//                flushes the synchronizer, takes two samples and reports the
//                first sample plus a per-cell "still oscillating" flag.
//  Revision    : 1.0  initial release
// ============================================================================
module rram_ctrl
    import rram_pkg::*;
#(
    parameter int CELLS = 64,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] off_cycles,
    input  logic [CNT_W-1:0] on_cycles,
    input  logic [CELLS-1:0] cell_mask,
    output logic [CELLS-1:0] en,
    input  logic [CELLS-1:0] cell_out,
    output logic             busy,
    output logic             done,
    output logic [CELLS-1:0] data,
    output logic [CELLS-1:0] unstable
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] on_q, on_d;
    logic [CELLS-1:0] mask_q, mask_d;
    logic [CELLS-1:0] samp1_q, samp1_d;
    logic [CELLS-1:0] unst_q, unst_d;
    logic [CELLS-1:0] data_q, data_d;
    logic [CELLS-1:0] unstable_q, unstable_d;
    logic [CELLS-1:0] en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CELLS-1:0] sync_w;
    logic [CELLS-1:0] masked_w;

    rram_sync #(
        .WIDTH (CELLS)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (cell_out),
        .sync_o  (sync_w)
    );

    assign masked_w = sync_w & mask_q;

    // Next-state, counter and capture logic; en is derived from the next
    // state so the registered enable switches cleanly on state boundaries
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        on_d       = on_q;
        mask_d     = mask_q;
        samp1_d    = samp1_q;
        unst_d     = unst_q;
        data_d     = data_q;
        unstable_d = unstable_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        en_d       = '0;

        case (state_q)
            IDLE: begin
                // A start landing on the done cycle belongs to the run that
                // just ended and is dropped
                if (start && !done_q) begin
                    state_d = DISCHARGE;
                    cnt_d   = off_cycles;
                    on_d    = on_cycles;
                    mask_d  = cell_mask;
                    busy_d  = 1'b1;
                end
            end
            DISCHARGE: begin
                if (cnt_q == '0) begin
                    state_d = POWER;
                    cnt_d   = on_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            POWER: begin
                if (cnt_q == '0) begin
                    state_d = SYNC;
                    cnt_d   = CNT_W'(SYNC_STAGES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SYNC: begin
                if (cnt_q == '0) begin
                    state_d = SAMP1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SAMP1: begin
                samp1_d = masked_w;
                state_d = SAMP2;
            end
            SAMP2: begin
                unst_d  = samp1_q ^ masked_w;
                state_d = FINISH;
            end
            FINISH: begin
                data_d     = samp1_q;
                unstable_d = unst_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        case (state_d)
            POWER, SYNC, SAMP1, SAMP2: en_d = mask_d;
            default:                   en_d = '0;
        endcase
    end

    // State and datapath registers; reset drops en immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            on_q       <= '0;
            mask_q     <= '0;
            samp1_q    <= '0;
            unst_q     <= '0;
            data_q     <= '0;
            unstable_q <= '0;
            en_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            on_q       <= on_d;
            mask_q     <= mask_d;
            samp1_q    <= samp1_d;
            unst_q     <= unst_d;
            data_q     <= data_d;
            unstable_q <= unstable_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign en       = en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign data     = data_q;
    assign unstable = unstable_q;

endmodule
`default_nettype wire

// File: tb/tb_rram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rram_ctrl
//  Description : Directed self-checking bench for rram_ctrl. Latency is
//                counted in clock edges after the edge that accepts start:
//                (off+1)+(on+1)+2+1+1+1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rram_ctrl;

    localparam int CELLS = 64;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] off_cycles;
    logic [CNT_W-1:0] on_cycles;
    logic [CELLS-1:0] cell_mask;
    logic [CELLS-1:0] en;
    logic [CELLS-1:0] cell_out;
    logic             busy;
    logic             done;
    logic [CELLS-1:0] data;
    logic [CELLS-1:0] unstable;

    logic [CELLS-1:0] cell_base;
    logic             osc_en;
    logic             osc_q;
    int               done_cnt;
    int               n_checks;
    int               n_errors;

    rram_ctrl #(
        .CELLS (CELLS),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .off_cycles (off_cycles),
        .on_cycles  (on_cycles),
        .cell_mask  (cell_mask),
        .en         (en),
        .cell_out   (cell_out),
        .busy       (busy),
        .done       (done),
        .data       (data),
        .unstable   (unstable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cell 3 toggles every cycle when oscillation is enabled
    always @(negedge clk) osc_q <= osc_en ? ~osc_q : 1'b0;
    assign cell_out = cell_base ^ {{(CELLS-4){1'b0}}, osc_q, 3'b000};

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full sequence, checking en/busy every cycle and the result at done
    task automatic run_seq(input logic [15:0] off, input logic [15:0] on,
                           input logic [63:0] mask, input logic [63:0] exp_data,
                           input logic [63:0] exp_unst, input logic [63:0] care,
                           input bit busy_starts);
        int lat;
        int exp_lat;
        int d0;
        logic [63:0] exp_en;
        exp_lat = int'(off) + int'(on) + 7;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; off_cycles = off; on_cycles = on; cell_mask = mask;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        check("busy_rise", {63'd0, busy}, 64'd1);
        while (!done && lat < 300) begin
            exp_en = (lat >= int'(off) + 1 && lat <= exp_lat - 2) ? mask : 64'd0;
            check("en_cycle", en, exp_en);
            check("busy_cycle", {63'd0, busy}, 64'd1);
            start = busy_starts && (lat == int'(off) + 1);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("latency", 64'(lat), 64'(exp_lat));
        check("en_at_done", en, 64'd0);
        check("busy_at_done", {63'd0, busy}, 64'd0);
        check("data", data & care, exp_data & care);
        check("unstable", unstable, exp_unst);
        if (busy_starts) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("done_start_ignored", {63'd0, busy}, 64'd0);
            repeat (30) @(negedge clk);
            check("no_extra_run", {63'd0, busy}, 64'd0);
        end
        @(negedge clk);
        check("one_done", 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int d0;
        int lat;
        n_checks = 0; n_errors = 0; done_cnt = 0;
        rst_n = 1'b0; start = 1'b0; off_cycles = '0; on_cycles = '0;
        cell_mask = '0; cell_base = '0; osc_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_en", en, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_data", data, 64'd0);
        check("rst_unstable", unstable, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", {63'd0, busy}, 64'd0);

        // Basic read: static pattern, all cells enabled
        cell_base = 64'hA5C3_0F96_1234_FEDC;
        run_seq(16'd3, 16'd5, {64{1'b1}}, 64'hA5C3_0F96_1234_FEDC, 64'd0, {64{1'b1}}, 1'b0);

        // Results hold after the input changes
        cell_base = 64'h1111_2222_3333_4444;
        repeat (5) @(negedge clk);
        check("data_hold", data, 64'hA5C3_0F96_1234_FEDC);
        check("unstable_hold", unstable, 64'd0);

        // Masking: only low byte enabled and readable
        cell_base = {64{1'b1}};
        run_seq(16'd2, 16'd4, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_00FF,
                64'd0, {64{1'b1}}, 1'b0);

        // Oscillating cell 3 flagged unstable, its data bit undefined
        cell_base = 64'h0F0F_0000_FFFF_00F0;
        osc_en = 1'b1;
        run_seq(16'd1, 16'd3, {64{1'b1}}, 64'h0F0F_0000_FFFF_00F0, 64'h8,
                ~64'h8, 1'b0);
        osc_en = 1'b0;

        // Boundary: zero counter loads
        cell_base = 64'h0123_4567_89AB_CDEF;
        run_seq(16'd0, 16'd0, {64{1'b1}}, 64'h0123_4567_89AB_CDEF, 64'd0, {64{1'b1}}, 1'b0);

        // Start pulses while busy and on the done cycle are ignored
        cell_base = 64'hDEAD_BEEF_CAFE_F00D;
        run_seq(16'd2, 16'd6, 64'hFFFF_0000_FFFF_0000, 64'hDEAD_0000_CAFE_0000,
                64'd0, {64{1'b1}}, 1'b1);

        // Mid-run reset during POWER
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; off_cycles = 16'd2; on_cycles = 16'd10; cell_mask = 64'h00FF_FF00;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (lat < 4) begin
            @(negedge clk);
            lat++;
        end
        check("en_before_reset", en, 64'h00FF_FF00);
        rst_n = 1'b0;
        #1;
        check("reset_en_drop", en, 64'd0);
        check("reset_busy_drop", {63'd0, busy}, 64'd0);
        check("reset_data_clear", data, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("reset_no_done", 64'(done_cnt - d0), 64'd0);
        check("reset_idle", {63'd0, busy}, 64'd0);

        cell_base = 64'h5555_AAAA_5555_AAAA;
        run_seq(16'd1, 16'd2, {64{1'b1}}, 64'h5555_AAAA_5555_AAAA, 64'd0, {64{1'b1}}, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
